// File: rtl/final_fpga_cpu_ocimem_arbiter.sv
// final_fpga_cpu_ocimem_arbiter
// Sequences the Nios II on-chip debug memory (single-port RAM, 1-cycle read
// latency) between the JTAG debug path and the CPU Avalon-MM debug slave.
// JTAG grants and CPU grants alternate under contention so neither starves.
// Optional build macro: OCIMEM_WRPROT_EN -- CPU writes below ROM_WORDS are
// acknowledged but never reach the RAM.
module final_fpga_cpu_ocimem_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int ROM_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              av_chipselect,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [ADDR_W-1:0] av_address,
    input  logic [DATA_W-1:0] av_writedata,
    output logic [DATA_W-1:0] av_readdata,
    output logic              av_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_en,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              jtag_overrun
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_JRD  = 2'd1,
        ST_CRD  = 2'd2
    } state_t;

    typedef enum logic {
        LG_JTAG = 1'b0,
        LG_CPU  = 1'b1
    } grant_t;

    state_t              r_state;
    state_t              w_state_nxt;
    grant_t              r_last_grant;
    logic [ADDR_W-1:0]   r_jtag_addr;
    logic [DATA_W-1:0]   r_jdata;
    logic                r_jpend_wr;
    logic                r_jpend_rd;
    logic [DATA_W-1:0]   r_mon_dreg;
    logic                r_monitor_ready;
    logic                r_jtag_overrun;
    logic [DATA_W-1:0]   r_av_readdata;

    logic                w_jtag_req;
    logic                w_cpu_req;
    logic                w_jbusy;
    logic                w_acc_b;
    logic                w_acc_rd;
    logic                w_drop;
    logic                w_grant_jtag;
    logic                w_grant_cpu;
    logic                w_jwr_done;
    logic                w_jrd_done;
    logic                w_cpu_wr_blocked;
    logic [5:0]          w_unused_jdo;

    // jdo carries fields for several debug instructions; only address and data matter here
    assign w_unused_jdo = {jdo[37:35], jdo[2:0]};

`ifdef OCIMEM_WRPROT_EN
    assign w_cpu_wr_blocked = (32'(av_address) < 32'(ROM_WORDS));
`else
    logic w_unused_rom;
    assign w_cpu_wr_blocked = 1'b0;
    assign w_unused_rom     = (32'(av_address) < 32'(ROM_WORDS));
`endif

    assign w_jtag_req = r_jpend_wr | r_jpend_rd;
    assign w_cpu_req  = av_chipselect & (av_read | av_write);

    // A JTAG data strobe is only taken when no JTAG operation is in flight
    assign w_jbusy  = r_jpend_wr | r_jpend_rd | (r_state == ST_JRD);
    assign w_acc_b  = take_action_ocimem_b & ~take_action_ocimem_a & ~w_jbusy;
    assign w_acc_rd = take_no_action_ocimem_a & ~take_action_ocimem_a
                      & ~take_action_ocimem_b & ~w_jbusy;
    assign w_drop   = (take_action_ocimem_b & ~w_acc_b)
                      | (take_no_action_ocimem_a & ~w_acc_rd);

    assign w_jwr_done = w_grant_jtag & r_jpend_wr;
    assign w_jrd_done = (r_state == ST_JRD);

    assign MonDReg       = r_mon_dreg;
    assign monitor_ready = r_monitor_ready;
    assign jtag_overrun  = r_jtag_overrun;

    // Grant arbitration, RAM command drive and next-state selection
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_jtag   = 1'b0;
        w_grant_cpu    = 1'b0;
        ram_en         = 1'b0;
        ram_we         = 1'b0;
        ram_addr       = {ADDR_W{1'b0}};
        ram_wdata      = {DATA_W{1'b0}};
        av_waitrequest = w_cpu_req;
        av_readdata    = r_av_readdata;
        if (!reset_n) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_jtag_req && !((r_last_grant == LG_JTAG) && w_cpu_req)) begin
                        w_grant_jtag = 1'b1;
                        ram_en       = 1'b1;
                        ram_addr     = r_jtag_addr;
                        if (r_jpend_wr) begin
                            ram_we    = 1'b1;
                            ram_wdata = r_jdata;
                        end else begin
                            w_state_nxt = ST_JRD;
                        end
                    end else if (w_cpu_req) begin
                        w_grant_cpu = 1'b1;
                        ram_addr    = av_address;
                        if (av_write) begin
                            // write wins when read and write are both raised
                            ram_en         = ~w_cpu_wr_blocked;
                            ram_we         = ~w_cpu_wr_blocked;
                            ram_wdata      = av_writedata;
                            av_waitrequest = 1'b0;
                        end else begin
                            ram_en      = 1'b1;
                            w_state_nxt = ST_CRD;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_JRD: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_CRD: begin
                    av_waitrequest = 1'b0;
                    av_readdata    = ram_rdata;
                    w_state_nxt    = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state and grant history
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= LG_JTAG;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_jtag) begin
                r_last_grant <= LG_JTAG;
            end else if (w_grant_cpu) begin
                r_last_grant <= LG_CPU;
            end
        end
    end

    // JTAG address pointer, pending requests and latched write data
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_jtag_addr <= {ADDR_W{1'b0}};
            r_jdata     <= {DATA_W{1'b0}};
            r_jpend_wr  <= 1'b0;
            r_jpend_rd  <= 1'b0;
        end else begin
            if (take_action_ocimem_a) begin
                r_jtag_addr <= jdo[ADDR_W+16:17];
            end else if (w_jwr_done || w_jrd_done) begin
                r_jtag_addr <= r_jtag_addr + ADDR_W'(1);
            end
            if (w_acc_b) begin
                r_jpend_wr <= 1'b1;
                r_jdata    <= jdo[34:3];
            end else if (w_jwr_done) begin
                r_jpend_wr <= 1'b0;
            end
            if (w_acc_rd) begin
                r_jpend_rd <= 1'b1;
            end else if (w_jrd_done) begin
                r_jpend_rd <= 1'b0;
            end
        end
    end

    // JTAG status: read-back register, completion level and sticky overrun
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mon_dreg      <= {DATA_W{1'b0}};
            r_monitor_ready <= 1'b0;
            r_jtag_overrun  <= 1'b0;
        end else begin
            if (w_jrd_done) begin
                r_mon_dreg <= ram_rdata;
            end
            if (w_acc_b || w_acc_rd) begin
                r_monitor_ready <= 1'b0;
            end else if (w_jwr_done || w_jrd_done) begin
                r_monitor_ready <= 1'b1;
            end
            if (w_drop) begin
                r_jtag_overrun <= 1'b1;
            end
        end
    end

    // Hold the last CPU read word so av_readdata is stable outside CRD
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_av_readdata <= {DATA_W{1'b0}};
        end else if (r_state == ST_CRD) begin
            r_av_readdata <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_final_fpga_cpu_ocimem_arbiter.sv
// Directed self-checking bench for final_fpga_cpu_ocimem_arbiter with a
// behavioural 256x32 single-port RAM (1-cycle read latency).
module tb_final_fpga_cpu_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic        av_chipselect;
    logic        av_read;
    logic        av_write;
    logic [7:0]  av_address;
    logic [31:0] av_writedata;
    logic [31:0] av_readdata;
    logic        av_waitrequest;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_rdata = 32'h0;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        jtag_overrun;

    logic [31:0] mem [256] = '{default: 32'h0};

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    final_fpga_cpu_ocimem_arbiter dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .av_chipselect           (av_chipselect),
        .av_read                 (av_read),
        .av_write                (av_write),
        .av_address              (av_address),
        .av_writedata            (av_writedata),
        .av_readdata             (av_readdata),
        .av_waitrequest          (av_waitrequest),
        .ram_addr                (ram_addr),
        .ram_wdata               (ram_wdata),
        .ram_en                  (ram_en),
        .ram_we                  (ram_we),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .jtag_overrun            (jtag_overrun)
    );

    // OCIMEM model: synchronous write, registered read
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input logic [7:0] addr);
        jdo = 38'(addr) << 17;
        take_action_ocimem_a = 1'b1;
        step();
        take_action_ocimem_a = 1'b0;
    endtask

    task automatic pulse_b(input logic [31:0] data);
        jdo = 38'(data) << 3;
        take_action_ocimem_b = 1'b1;
        step();
        take_action_ocimem_b = 1'b0;
    endtask

    task automatic pulse_rd();
        take_no_action_ocimem_a = 1'b1;
        step();
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic cpu_idle();
        av_chipselect = 1'b0;
        av_read       = 1'b0;
        av_write      = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_wait;
        logic [7:0] exp_we;

        reset_n = 1'b0;
        jdo = 38'h0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        av_address = 8'h0;
        av_writedata = 32'h0;
        cpu_idle();
        step();
        step();

        // reset state
        check_val("rst_mon_ready", {31'h0, monitor_ready}, 32'h0);
        check_val("rst_overrun",   {31'h0, jtag_overrun}, 32'h0);
        check_val("rst_mondreg",   MonDReg, 32'h0);
        check_val("rst_readdata",  av_readdata, 32'h0);
        check_val("rst_ram_en",    {31'h0, ram_en}, 32'h0);
        check_val("rst_ram_we",    {31'h0, ram_we}, 32'h0);
        reset_n = 1'b1;
        step();
        check_val("idle_waitreq",  {31'h0, av_waitrequest}, 32'h0);

        // JTAG write 0x10 <= DEADBEEF, then auto-increment to 0x11
        pulse_a(8'h10);
        check_val("a_no_ram_en", {31'h0, ram_en}, 32'h0);
        pulse_b(32'hDEADBEEF);
        check_val("jwr_en",    {31'h0, ram_en}, 32'h1);
        check_val("jwr_we",    {31'h0, ram_we}, 32'h1);
        check_val("jwr_addr",  {24'h0, ram_addr}, 32'h10);
        check_val("jwr_wdata", ram_wdata, 32'hDEADBEEF);
        check_val("jwr_busy_ready", {31'h0, monitor_ready}, 32'h0);
        step();
        check_val("jwr_ready", {31'h0, monitor_ready}, 32'h1);
        check_val("jwr_mem",   mem[8'h10], 32'hDEADBEEF);
        pulse_b(32'h11111111);
        check_val("jwr_incr_addr", {24'h0, ram_addr}, 32'h11);
        step();
        check_val("jwr_mem2", mem[8'h11], 32'h11111111);

        // JTAG read back 0x10, ready exactly three cycles after the strobe
        pulse_a(8'h10);
        pulse_rd();
        check_val("jrd_en",    {31'h0, ram_en}, 32'h1);
        check_val("jrd_we",    {31'h0, ram_we}, 32'h0);
        check_val("jrd_addr",  {24'h0, ram_addr}, 32'h10);
        check_val("jrd_ready_c1", {31'h0, monitor_ready}, 32'h0);
        step();
        check_val("jrd_ready_c2", {31'h0, monitor_ready}, 32'h0);
        check_val("jrd_jrd_en",   {31'h0, ram_en}, 32'h0);
        step();
        check_val("jrd_ready_c3", {31'h0, monitor_ready}, 32'h1);
        check_val("jrd_mondreg",  MonDReg, 32'hDEADBEEF);
        pulse_rd();
        step();
        step();
        check_val("jrd_incr_mondreg", MonDReg, 32'h11111111);

        // address wrap 0xFF -> 0x00
        pulse_a(8'hFF);
        pulse_b(32'hA5A5A5A5);
        check_val("wrap_addr_ff", {24'h0, ram_addr}, 32'hFF);
        step();
        pulse_b(32'h5A5A5A5A);
        check_val("wrap_addr_00", {24'h0, ram_addr}, 32'h00);
        check_val("wrap_we",      {31'h0, ram_we}, 32'h1);
        step();
        check_val("wrap_mem_ff", mem[8'hFF], 32'hA5A5A5A5);
        check_val("wrap_mem_00", mem[8'h00], 32'h5A5A5A5A);

        // CPU write with read and write both raised is a write
        av_chipselect = 1'b1; av_read = 1'b1; av_write = 1'b1;
        av_address = 8'h20; av_writedata = 32'hCAFE0020;
        #1;
        check_val("cwr_waitreq", {31'h0, av_waitrequest}, 32'h0);
        check_val("cwr_we",      {31'h0, ram_we}, 32'h1);
        check_val("cwr_addr",    {24'h0, ram_addr}, 32'h20);
        step();
        cpu_idle();
        check_val("cwr_mem", mem[8'h20], 32'hCAFE0020);

        // contention: CPU read of 0x20 held, JTAG writes every 4 cycles
        pulse_a(8'h30);
        exp_wait = 8'b01101101;
        exp_we   = 8'b00100100;
        av_chipselect = 1'b1; av_read = 1'b1; av_address = 8'h20;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin jdo = 38'(32'h1111AAAA) << 3; take_action_ocimem_b = 1'b1; end
            if (i == 4) begin jdo = 38'(32'h2222BBBB) << 3; take_action_ocimem_b = 1'b1; end
            #1;
            check_val($sformatf("cont_wait_c%0d", i), {31'h0, av_waitrequest}, {31'h0, exp_wait[i]});
            check_val($sformatf("cont_we_c%0d", i),   {31'h0, ram_we}, {31'h0, exp_we[i]});
            if (!exp_wait[i])
                check_val($sformatf("cont_rdata_c%0d", i), av_readdata, 32'hCAFE0020);
            step();
            take_action_ocimem_b = 1'b0;
        end
        cpu_idle();
        #1;
        check_val("cont_idle_wait", {31'h0, av_waitrequest}, 32'h0);
        check_val("cont_mem30",  mem[8'h30], 32'h1111AAAA);
        check_val("cont_mem31",  mem[8'h31], 32'h2222BBBB);
        check_val("cont_no_ovr", {31'h0, jtag_overrun}, 32'h0);

        // overrun: read strobe, then write strobe next cycle is dropped
        pulse_a(8'h10);
        pulse_rd();
        pulse_b(32'h12345678);
        step();
        step();
        step();
        check_val("ovr_flag",    {31'h0, jtag_overrun}, 32'h1);
        check_val("ovr_mem11",   mem[8'h11], 32'h11111111);
        check_val("ovr_mondreg", MonDReg, 32'hDEADBEEF);
        check_val("ovr_ready",   {31'h0, monitor_ready}, 32'h1);

        // reset while in JRD aborts the read
        pulse_a(8'h10);
        pulse_rd();
        step();
        reset_n = 1'b0;
        #1;
        check_val("rjrd_en_rst_cycle", {31'h0, ram_en}, 32'h0);
        step();
        check_val("rjrd_mondreg", MonDReg, 32'h0);
        check_val("rjrd_ready",   {31'h0, monitor_ready}, 32'h0);
        check_val("rjrd_overrun", {31'h0, jtag_overrun}, 32'h0);
        reset_n = 1'b1;
        #1;
        check_val("rjrd_en_after", {31'h0, ram_en}, 32'h0);
        step();
        check_val("rjrd_en_after2", {31'h0, ram_en}, 32'h0);
        check_val("rjrd_ready2",    {31'h0, monitor_ready}, 32'h0);

        // reset in a JTAG write grant cycle: no RAM access
        pulse_a(8'h50);
        pulse_b(32'h00000077);
        reset_n = 1'b0;
        #1;
        check_val("rwr_we_rst_cycle", {31'h0, ram_we}, 32'h0);
        step();
        reset_n = 1'b1;
        step();
        step();
        check_val("rwr_mem50", mem[8'h50], 32'h0);

        // simultaneous a and b: b dropped with overrun
        jdo = 38'(8'h60) << 17;
        take_action_ocimem_a = 1'b1;
        take_action_ocimem_b = 1'b1;
        step();
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        check_val("sim_overrun", {31'h0, jtag_overrun}, 32'h1);
        check_val("sim_no_en",   {31'h0, ram_en}, 32'h0);
        step();
        check_val("sim_ready",   {31'h0, monitor_ready}, 32'h0);

        // CPU writes into and above the low region
        av_chipselect = 1'b1; av_write = 1'b1;
        av_address = 8'h05; av_writedata = 32'h55555555;
        #1;
        check_val("wp05_waitreq", {31'h0, av_waitrequest}, 32'h0);
`ifdef OCIMEM_WRPROT_EN
        check_val("wp05_we", {31'h0, ram_we}, 32'h0);
`else
        check_val("wp05_we", {31'h0, ram_we}, 32'h1);
`endif
        step();
        cpu_idle();
`ifdef OCIMEM_WRPROT_EN
        check_val("wp05_mem", mem[8'h05], 32'h0);
`else
        check_val("wp05_mem", mem[8'h05], 32'h55555555);
`endif
        av_chipselect = 1'b1; av_write = 1'b1;
        av_address = 8'h40; av_writedata = 32'h40404040;
        #1;
        check_val("wp40_we", {31'h0, ram_we}, 32'h1);
        step();
        cpu_idle();
        check_val("wp40_mem", mem[8'h40], 32'h40404040);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/final_fpga_cpu_ocimem_arbiter.md
Name: final_fpga_cpu_ocimem_arbiter

Overview:
- Sequences and arbitrates the Nios II on-chip debug memory (OCIMEM), a single-port RAM with 1-cycle read latency.
- Two requesters share it:
  - the JTAG debug path, which issues sysclk-domain take_action strobes plus the jdo shift data;
  - the CPU's Avalon-MM debug slave.
- Returns JTAG read data in MonDReg and signals completion on monitor_ready.
- Sits between the debug-module sysclk logic and the OCIMEM RAM instance.

Parameters:
- ADDR_W, 8, OCIMEM word-address width.
- DATA_W, 32, data width; fixed at 32 to match MonDReg and jdo[34:3].
- ROM_WORDS, 64, size of the write-protected low region. Used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; synchronous, active-low.
- jdo  in  38  JTAG shift data. Address field is jdo[ADDR_W+16:17]; write-data field is jdo[34:3].
- take_action_ocimem_a  in  1  1-cycle strobe: load JTAG address.
- take_action_ocimem_b  in  1  1-cycle strobe: JTAG write, then address auto-increment.
- take_no_action_ocimem_a  in  1  1-cycle strobe: JTAG read, then address auto-increment.
- av_chipselect  in  1  CPU Avalon select.
- av_read  in  1  CPU Avalon read.
- av_write  in  1  CPU Avalon write.
- av_address  in  ADDR_W  CPU Avalon word address.
- av_writedata  in  32  CPU Avalon write data.
- av_readdata  out  32  CPU Avalon read data.
- av_waitrequest  out  1  CPU Avalon stall.
- ram_addr  out  ADDR_W  OCIMEM address.
- ram_wdata  out  32  OCIMEM write data.
- ram_en  out  1  OCIMEM access enable.
- ram_we  out  1  OCIMEM write enable.
- ram_rdata  in  32  OCIMEM read data, valid the cycle after ram_en with ram_we=0.
- MonDReg  out  32  last JTAG read data.
- monitor_ready  out  1  level signal: JTAG operation complete.
- jtag_overrun  out  1  sticky flag: JTAG strobe dropped while an operation was pending.

Behaviour:
- Reset values (reset_n=0 sampled at a rising edge):
  - FSM to IDLE; JTAG pending operations cleared.
  - jtag_addr=0, MonDReg=0, av_readdata=0.
  - monitor_ready=0, jtag_overrun=0.
  - ram_en=0, ram_we=0.
- Reset asserted mid-operation aborts it. No RAM access is issued in the reset cycle.
- JTAG strobes:
  - take_action_ocimem_a: jtag_addr <= jdo[ADDR_W+16:17] next cycle. No RAM access; monitor_ready unchanged.
  - take_action_ocimem_b: set jpend_wr and latch jdata <= jdo[34:3]; clear monitor_ready.
  - take_no_action_ocimem_a: set jpend_rd; clear monitor_ready.
  - Simultaneous strobes: priority a > b > no_action_a. Lower-priority strobes are dropped and jtag_overrun is set.
  - A b or no_action_a strobe while jpend_wr, jpend_rd or JRD is active is dropped and sets jtag_overrun.
  - jtag_overrun clears only on reset.
- FSM states: IDLE, JRD, CRD.
- IDLE grant rules:
  - A JTAG request is pending when jpend_wr or jpend_rd is set.
  - The CPU requests when av_chipselect & (av_read | av_write).
  - JTAG wins unless last_grant==JTAG and the CPU is requesting; then the CPU wins. This alternation prevents starvation.
  - last_grant updates on every grant.
- JTAG write (IDLE):
  - Drive ram_en=1, ram_we=1, ram_addr=jtag_addr, ram_wdata=jdata for one cycle.
  - Next cycle: jtag_addr += 1 (wraps modulo 2^ADDR_W), jpend_wr=0, monitor_ready=1. Stay in IDLE.
- JTAG read:
  - IDLE: drive ram_en=1, ram_we=0; go to JRD.
  - JRD: MonDReg <= ram_rdata, jtag_addr += 1 (wrap), jpend_rd=0, monitor_ready=1; return to IDLE.
  - Strobe to monitor_ready is at least 3 cycles.
- CPU write:
  - Granted in IDLE: ram_en=1, ram_we=1 with av_address/av_writedata.
  - av_waitrequest=0 in that same cycle. Stay in IDLE.
- CPU read:
  - Granted in IDLE: ram_en=1, ram_we=0, av_waitrequest=1; go to CRD.
  - CRD: av_readdata=ram_rdata (combinational pass), av_waitrequest=0; return to IDLE.
- av_waitrequest=1 whenever the CPU requests and is not completing in the current cycle. It is 0 when not requesting.
- If av_read and av_write are both asserted, the access is treated as a write.
- ram_en and ram_we are 0 in every cycle without a grant.

Optional Feature:
- Macro OCIMEM_WRPROT_EN.
- Defined:
  - CPU writes with av_address < ROM_WORDS complete normally (waitrequest=0 for one cycle) but ram_we=0 and ram_en=0.
  - JTAG writes are unaffected.
- Undefined: all writes reach the RAM; ROM_WORDS is ignored.

Test Plan:
- JTAG write then read back:
  - a with jdo addr=0x10, then b with jdo[34:3]=0xDEADBEEF → RAM[0x10] written, jtag_addr=0x11.
  - a addr=0x10, then no_action_a → MonDReg=0xDEADBEEF, monitor_ready=1 three cycles after the strobe.
- Address wrap: a addr=0xFF, b → jtag_addr=0x00 next cycle.
- Contention:
  - CPU read of 0x20 held continuously while JTAG issues writes every 4 cycles.
  - Grants alternate; CPU read completes (waitrequest low in CRD) within 3 cycles of the first JTAG grant.
- Overrun: no_action_a followed by b on the next cycle → second strobe dropped, jtag_overrun=1, RAM unchanged.
- Reset mid-read: reset_n=0 while in JRD → next cycle state IDLE, MonDReg=0, monitor_ready=0, ram_en=0.
- With OCIMEM_WRPROT_EN:
  - CPU write to 0x05 → ram_we never asserted, waitrequest low for 1 cycle.
  - CPU write to 0x40 → RAM written.
